cc_lane_speed_ticker: RTL and testbench

//  Multi-lane programmable speed-tick generator for the Frogger datapath.

---
 rtl/cc_lane_speed_ticker.sv | 67 ++++++
 tb/tb_cc_lane_speed_ticker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cc_lane_speed_ticker.sv
// cc_lane_speed_ticker: per-lane programmable period counters emitting one-cycle active-low ticks
module cc_lane_speed_ticker #(
  parameter int DATAWIDTH      = 23,
  parameter int LANES          = 4,
  parameter int ADDRWIDTH      = 2,
  parameter int DEFAULT_PERIOD = 8480,
  parameter int MIN_PERIOD     = 16,
  parameter int LEVELWIDTH     = 4,
  parameter int LEVEL_STEP     = 256
) (
  input  logic                  CC_SPEEDTICKER_CLOCK_50,
  input  logic                  CC_SPEEDTICKER_RESET_InHigh,
  input  logic                  CC_SPEEDTICKER_pause_InHigh,
  input  logic [LEVELWIDTH-1:0] CC_SPEEDTICKER_level_InBUS,
  input  logic                  CC_SPEEDTICKER_wr_InHigh,
  input  logic [ADDRWIDTH-1:0]  CC_SPEEDTICKER_addr_InBUS,
  input  logic [DATAWIDTH-1:0]  CC_SPEEDTICKER_data_InBUS,
  output logic [LANES-1:0]      CC_SPEEDTICKER_tick_OutLow
);
  localparam int EW = DATAWIDTH + LEVELWIDTH;
  localparam logic [DATAWIDTH-1:0] MIN_D = DATAWIDTH'(MIN_PERIOD);
  localparam logic [EW-1:0] MIN_E = EW'(MIN_PERIOD);
  logic [DATAWIDTH-1:0] cnt_q [LANES];
  logic [DATAWIDTH-1:0] cnt_d [LANES];
  logic [DATAWIDTH-1:0] per_q [LANES];
  logic [DATAWIDTH-1:0] per_d [LANES];
  logic [EW-1:0]        diff  [LANES];
  logic [EW-1:0]        eff   [LANES];
  logic [EW-1:0]        step;
  logic [DATAWIDTH-1:0] wdata;
  logic [LANES-1:0]     tick_q, tick_d, hit, term;
  // Effective period with level speed-up at widened precision, then wrap/write/pause decisions per lane
  always_comb begin
    step   = EW'(CC_SPEEDTICKER_level_InBUS) * EW'(LEVEL_STEP);
    wdata  = CC_SPEEDTICKER_data_InBUS < MIN_D ? MIN_D : CC_SPEEDTICKER_data_InBUS;
    hit    = '0;
    term   = '0;
    tick_d = '1;
    diff   = '{default: '0};
    eff    = '{default: '0};
    cnt_d  = cnt_q;
    per_d  = per_q;
    for (int i = 0; i < LANES; i++) begin
      diff[i]   = EW'(per_q[i]) > step ? EW'(per_q[i]) - step : '0;
      eff[i]    = diff[i] < MIN_E ? MIN_E : diff[i];
      term[i]   = EW'(cnt_q[i]) >= eff[i] - EW'(1);
      hit[i]    = CC_SPEEDTICKER_wr_InHigh && CC_SPEEDTICKER_addr_InBUS == ADDRWIDTH'(i);
      per_d[i]  = hit[i] ? wdata : per_q[i];
      cnt_d[i]  = hit[i] || (!CC_SPEEDTICKER_pause_InHigh && term[i]) ? '0 :
                  CC_SPEEDTICKER_pause_InHigh ? cnt_q[i] : cnt_q[i] + DATAWIDTH'(1);
      tick_d[i] = hit[i] || CC_SPEEDTICKER_pause_InHigh || !term[i];
    end
  end
  // State registers; reset restores default periods and parks ticks high
  always_ff @(posedge CC_SPEEDTICKER_CLOCK_50) begin
    if (CC_SPEEDTICKER_RESET_InHigh) begin
      cnt_q  <= '{default: '0};
      per_q  <= '{default: DATAWIDTH'(DEFAULT_PERIOD)};
      tick_q <= '1;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      tick_q <= tick_d;
    end
  end
  assign CC_SPEEDTICKER_tick_OutLow = tick_q;
endmodule

// File: tb/tb_cc_lane_speed_ticker.sv
// tb_cc_lane_speed_ticker: scoreboard bench with hand-computed tick schedules
module tb_cc_lane_speed_ticker;
  logic       clk = 0, rst = 1, pause = 0, wr = 0;
  logic [3:0] level = 0;
  logic [1:0] addr = 0;
  logic [7:0] data = 0;
  logic [1:0] tick;
  logic       rst_d = 1, done = 0, closed = 0;
  int         cyc = 0, tests = 0, fails = 0, b = 0;
  typedef struct {
    int         c;
    logic [1:0] v;
  } ev_t;
  ev_t q[$];

  cc_lane_speed_ticker #(
    .DATAWIDTH(8), .LANES(2), .ADDRWIDTH(2), .DEFAULT_PERIOD(10),
    .MIN_PERIOD(4), .LEVELWIDTH(4), .LEVEL_STEP(2)
  ) dut (
    .CC_SPEEDTICKER_CLOCK_50    (clk),
    .CC_SPEEDTICKER_RESET_InHigh(rst),
    .CC_SPEEDTICKER_pause_InHigh(pause),
    .CC_SPEEDTICKER_level_InBUS (level),
    .CC_SPEEDTICKER_wr_InHigh   (wr),
    .CC_SPEEDTICKER_addr_InBUS  (addr),
    .CC_SPEEDTICKER_data_InBUS  (data),
    .CC_SPEEDTICKER_tick_OutLow (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  // Monitor: every low tick must match the head of the expected queue
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].c < cyc) begin
      tests++;
      fails++;
      $display("FAIL missed_tick cycle %0d: got none, want %b", q[0].c, q[0].v);
      void'(q.pop_front());
    end
    if (rst_d) begin
      tests++;
      if (tick !== 2'b11) begin
        fails++;
        $display("FAIL reset_tick cycle %0d: got %b, want 11", cyc, tick);
      end
    end else if (tick !== 2'b11) begin
      tests++;
      if (q.size() == 0 || q[0].c != cyc) begin
        fails++;
        $display("FAIL unexpected_tick cycle %0d: got %b, want 11", cyc, tick);
      end else begin
        if (tick !== q[0].v) begin
          fails++;
          $display("FAIL tick_value cycle %0d: got %b, want %b", cyc, tick, q[0].v);
        end
        void'(q.pop_front());
      end
    end
    if (done && !closed) begin
      closed = 1;
      tests++;
      if (q.size() != 0) begin
        fails++;
        $display("FAIL leftover_expect: got %0d pending, want 0", q.size());
      end
    end
  end

  function automatic void ex(int c, logic [1:0] v);
    ev_t e;
    e.c = c;
    e.v = v;
    q.push_back(e);
  endfunction

  task automatic at(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wrt(int a, int d);
    wr   = 1;
    addr = 2'(a);
    data = 8'(d);
    @(negedge clk);
    wr = 0;
  endtask

  task automatic go_reset();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    b   = cyc;
  endtask

  initial begin
    // Default periods, both lanes tick together every 10 cycles
    go_reset();
    ex(b + 10, 2'b00); ex(b + 20, 2'b00); ex(b + 30, 2'b00);
    at(b + 35);
    // Lane1 reprogrammed to 6, lane0 untouched
    go_reset();
    ex(b + 10, 2'b00); ex(b + 16, 2'b01); ex(b + 20, 2'b10);
    ex(b + 22, 2'b01); ex(b + 28, 2'b01); ex(b + 30, 2'b10);
    at(b + 3); wrt(1, 6);
    at(b + 32);
    // Lane0 written below floor -> 4; out-of-range address ignored
    go_reset();
    ex(b + 7, 2'b10);  ex(b + 10, 2'b01); ex(b + 11, 2'b10); ex(b + 15, 2'b10);
    ex(b + 19, 2'b10); ex(b + 20, 2'b01); ex(b + 23, 2'b10);
    at(b + 2); wrt(0, 2);
    at(b + 4); wrt(3, 5);
    at(b + 25);
    // Level speed-up, floor clamp, mid-count level raise, deep underflow
    level = 2;
    go_reset();
    ex(b + 6, 2'b00);  ex(b + 12, 2'b00); ex(b + 16, 2'b00); ex(b + 20, 2'b00);
    ex(b + 29, 2'b00); ex(b + 35, 2'b00); ex(b + 39, 2'b00); ex(b + 43, 2'b00);
    at(b + 12); level = 5;
    at(b + 20); level = 0;
    at(b + 28); level = 2;
    at(b + 35); level = 15;
    at(b + 45); level = 0;
    // Pause at cnt=5 for 7 cycles, with a lane1 write accepted while paused
    go_reset();
    ex(b + 17, 2'b10); ex(b + 18, 2'b01); ex(b + 24, 2'b01);
    ex(b + 27, 2'b10); ex(b + 30, 2'b01);
    at(b + 5);  pause = 1;
    at(b + 7);  wrt(1, 6);
    at(b + 12); pause = 0;
    at(b + 32);
    // Write on terminal count suppresses the tick, then reset mid-count
    go_reset();
    ex(b + 10, 2'b01); ex(b + 15, 2'b10); ex(b + 20, 2'b00);
    at(b + 9); wrt(0, 5);
    at(b + 23); rst = 1;
    at(b + 25); rst = 0;
    b = cyc;
    ex(b + 10, 2'b00); ex(b + 20, 2'b00);
    at(b + 22);
    done = 1;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
